// File: rtl/moving_avg_filter_mc.sv
// Multi-channel boxcar filter: per-channel running sum over the last 2^win_q frames,
// one shared frame-wide history RAM, flush-and-restart whenever the window changes.

module moving_avg_lane #(
  parameter int DATA_W = 24,
  parameter int AW     = 28,
  parameter int WSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc_en,
  input  logic              byp,
  input  logic [WSEL_W-1:0] win,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] old,
  output logic [DATA_W-1:0] dout
);
  logic signed [AW-1:0] acc_q, acc_d, acc_new, shr;
  logic signed [AW-1:0] din_x, old_x;
  logic [DATA_W-1:0]    dout_q, dout_d;

  always_comb begin
    din_x   = {{(AW-DATA_W){din[DATA_W-1]}}, din};
    old_x   = {{(AW-DATA_W){old[DATA_W-1]}}, old};
    acc_new = acc_q + din_x - old_x;
    // arithmetic shift floors toward -inf; sum of 2^win samples always fits DATA_W after it
    shr     = acc_new >>> win;
    acc_d   = acc_q;
    dout_d  = dout_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d  = acc_new;
      dout_d = byp ? din : DATA_W'(shr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

module moving_avg_filter_mc #(
  parameter  int DATA_W     = 24,
  parameter  int CH         = 2,
  parameter  int MAX_LOG2_N = 4,
  localparam int WSEL_W     = $clog2(MAX_LOG2_N+1)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] din,
  input  logic [WSEL_W-1:0]    win_log2,
  input  logic                 bypass,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] dout,
  output logic                 busy
);
  localparam int NMAX   = 1 << MAX_LOG2_N;
  localparam int ADDR_W = MAX_LOG2_N;
  localparam int AW     = DATA_W + MAX_LOG2_N;
  localparam logic [WSEL_W-1:0] WMAX = WSEL_W'(MAX_LOG2_N);

  typedef enum logic {S_FLUSH, S_RUN} state_e;
  typedef logic [CH-1:0][DATA_W-1:0] frame_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [WSEL_W-1:0] win_q, win_d;
  logic              out_valid_q, out_valid_d;

  logic [WSEL_W-1:0] win_clamp;
  logic              accept, clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  frame_t            wr_data, rd_data, din_f, dout_f;
  frame_t            mem_q [NMAX];

  assign din_f     = din;
  assign win_clamp = (win_log2 > WMAX) ? WMAX : win_log2;
  // oldest sample in the window; for the full window this wraps onto p itself
  assign rd_addr   = p_q - (ADDR_W'(1) << win_q);
  assign rd_data   = mem_q[rd_addr];

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    p_d         = p_q;
    win_d       = win_q;
    wr_en       = 1'b0;
    wr_addr     = p_q;
    wr_data     = din_f;
    accept      = 1'b0;
    clr         = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_FLUSH: begin
        busy        = 1'b1;
        clr         = 1'b1;
        wr_en       = 1'b1;
        wr_addr     = flush_cnt_q;
        wr_data     = '0;
        p_d         = '0;
        win_d       = win_clamp;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (&flush_cnt_q) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready = (win_clamp == win_q);
        if (!in_ready) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else if (in_valid) begin
          accept = 1'b1;
          wr_en  = 1'b1;
          p_d    = p_q + 1'b1;
        end
      end
      default: state_d = S_FLUSH;
    endcase
    out_valid_d = accept;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= '0;
      p_q         <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      p_q         <= p_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
    end
  end

  // history RAM is never reset: the flush sweep zeroes it before first use
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    moving_avg_lane #(.DATA_W(DATA_W), .AW(AW), .WSEL_W(WSEL_W)) u_lane (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .clr   (clr),
      .acc_en(accept),
      .byp   (bypass),
      .win   (win_q),
      .din   (din_f[g]),
      .old   (rd_data[g]),
      .dout  (dout_f[g])
    );
  end

  assign dout      = dout_f;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_moving_avg_filter_mc.sv
// Randomized bench for moving_avg_filter_mc against a queue-based average-of-last-N model.

module tb_moving_avg_filter_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, bypass, out_valid, busy;
  logic [47:0] din, dout;
  logic [2:0]  win_log2;

  moving_avg_filter_mc dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .win_log2 (win_log2),
    .bypass   (bypass),
    .out_valid(out_valid),
    .dout     (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          ql[$], qr[$];
  int          mw;
  bit          exp_rdy, exp_busy;
  logic [23:0] exp_l, exp_r;
  int          acc_cnt, ov_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampw(input int x);
    return (x > 4) ? 4 : x;
  endfunction

  // mean of the last 2^w accepted samples, missing history counted as zero, floored
  function automatic logic [23:0] mavg(input int q[$], input int w);
    longint s = 0;
    int     n = 1 << w;
    for (int i = 0; i < n && i < q.size(); i++) s += q[q.size()-1-i];
    s = s >>> w;
    return s[23:0];
  endfunction

  task automatic step(input bit v, input int l, input int r, input bit byp);
    bit take;
    in_valid = v;
    din      = {r[23:0], l[23:0]};
    bypass   = byp;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(exp_busy));
    take = v && exp_rdy;
    @(posedge clk); #1;
    if (take) begin
      ql.push_back(l); qr.push_back(r);
      if (ql.size() > 16) begin void'(ql.pop_front()); void'(qr.pop_front()); end
      exp_l = byp ? l[23:0] : mavg(ql, mw);
      exp_r = byp ? r[23:0] : mavg(qr, mw);
      acc_cnt++;
    end
    chk("out_valid", 64'(out_valid), 64'(take));
    chk("dout_l", 64'(dout[23:0]), 64'(exp_l));
    chk("dout_r", 64'(dout[47:24]), 64'(exp_r));
    if (out_valid) ov_cnt++;
  endtask

  task automatic do_reset(input int w);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    win_log2 = w[2:0];
    @(posedge clk); #1;
    rst_n = 1'b1;
    ql.delete(); qr.delete();
    mw = clampw(w);
    exp_l = '0; exp_r = '0;
    exp_rdy = 1'b0; exp_busy = 1'b1;
    repeat (16) step(0, 0, 0, 0);
    exp_rdy = 1'b1; exp_busy = 1'b0;
  endtask

  // a frame offered during the change is never accepted
  task automatic set_win(input int w, input bit v, input int l, input int r);
    win_log2 = w[2:0];
    if (clampw(w) != mw) begin
      exp_rdy = 1'b0; exp_busy = 1'b0;
      step(v, l, r, 0);
      exp_busy = 1'b1;
      repeat (16) step(v, l, r, 0);
      exp_rdy = 1'b1; exp_busy = 1'b0;
      ql.delete(); qr.delete();
      mw = clampw(w);
    end
  endtask

  initial begin
    in_valid = 1'b0; bypass = 1'b0; din = '0; win_log2 = 3'd3;
    acc_cnt = 0; ov_cnt = 0;

    // reset and step response
    do_reset(3);
    for (int i = 0; i < 8; i++) step(1, 800, 800, 0);
    chk("t2_step_end", 64'(dout[23:0]), 64'd800);
    for (int i = 0; i < 20; i++) step(1, 800, 800, 0);

    // sign and channel independence
    set_win(2, 0, 0, 0);
    step(1, -4, 400, 0);
    chk("t3_l1", 64'(dout[23:0]), 64'hFFFFFF);
    chk("t3_r1", 64'(dout[47:24]), 64'd100);
    for (int i = 0; i < 3; i++) step(1, -4, 400, 0);
    chk("t3_l4", 64'(dout[23:0]), 64'hFFFFFC);

    // window change while the source keeps offering frames
    set_win(3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1000, 1000, 0);
    set_win(1, 1, 7, 7);
    step(1, 1000, 0, 0);
    chk("t4_first", 64'(dout[23:0]), 64'd500);
    step(1, 1000, 0, 0);
    chk("t4_second", 64'(dout[23:0]), 64'd1000);

    // full scale with gaps
    set_win(4, 0, 0, 0);
    acc_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < 300 && acc_cnt < 16; i++)
      step(bit'($urandom_range(0, 1)), 32'h7FFFFF, -8388608, 0);
    chk("t5_l", 64'(dout[23:0]), 64'h7FFFFF);
    chk("t5_r", 64'(dout[47:24]), 64'h800000);
    chk("t5_cnt", 64'(ov_cnt), 64'(acc_cnt));

    // bypass
    step(1, 32'h123456, 32'h123456, 1);
    chk("t6_byp", 64'(dout[23:0]), 64'h123456);
    set_win(3, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 32'h123456, 32'h654321, 1);
    step(1, 32'h123456, 32'h654321, 0);
    chk("t6_avg", 64'(dout[23:0]), 64'h123456);
    set_win(5, 0, 0, 0);
    set_win(4, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, int'($urandom) >>> 8, int'($urandom) >>> 8, 0);

    // randomized traffic, window changes and a mid-stream reset
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_win(int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)), 5, 5);
      if (i == 250) do_reset(int'($urandom_range(0, 5)));
      step(bit'($urandom_range(0, 3) != 0), int'($urandom) >>> 8, int'($urandom) >>> 8,
           bit'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
